// File: rtl/jtframe_pll_supervisor.sv
// PLL lock supervisor and reset sequencer.
// Watches the PLL lock flag in the clk_sys domain and pulses the PLL reset
// when lock is lost. It also produces the system reset and the game reset,
// which are held while the clock tree or the ROM download is not ready.
//
// Ports:
//   clk_sys     in  system clock
//   RESET       in  asynchronous active-high master reset
//   pll_locked  in  PLL lock flag (asynchronous, synchronised here)
//   rst_req     in  user/OSD reset request, level sensitive
//   downloading in  ROM download in progress
//   pll_rst     out PLL reset, active high
//   rst         out system reset, active high (rst_n = ~rst)
//   game_rst    out game core reset, active high (game_rst_n = ~game_rst)
//
// PLL reset controller states:
//   state | meaning
//   IDLE  | pll_rst low, counter runs down to 0 and holds there
//   PULSE | pll_rst high until the counter expires
module jtframe_pll_supervisor #(
  parameter int         PLL_RST_LEN = 256,
  parameter logic [7:0] INIT_CNT    = 8'hD0,
  parameter int         RST_LEN     = 16
) (
  input  logic clk_sys,
  input  logic RESET,
  input  logic pll_locked,
  input  logic rst_req,
  input  logic downloading,
  output logic pll_rst,
  output logic rst,
  output logic rst_n,
  output logic game_rst,
  output logic game_rst_n
);

  localparam logic [7:0] PULSE_LOAD = 8'(PLL_RST_LEN - 1);
  localparam logic [7:0] RST_LOAD   = 8'(RST_LEN);

  typedef enum logic {IDLE, PULSE} state_t;

  state_t     st;
  logic [7:0] cnt;
  logic [7:0] rcnt;
  logic [7:0] gcnt;
  logic       lk_m, lk_s, last_locked;
  logic       lock_loss;
  logic       rst_src;
  logic       game_src;

  // Two-flop synchroniser plus one history flop for edge detection.
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      lk_m        <= 1'b0;
      lk_s        <= 1'b0;
      last_locked <= 1'b0;
    end else begin
      lk_m        <= pll_locked;
      lk_s        <= lk_m;
      last_locked <= lk_s;
    end
  end

  assign lock_loss = last_locked & ~lk_s;

  // A loss while already pulsing reloads the counter and so stretches the
  // pulse. The power-up INIT_CNT value only counts down in IDLE.
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      st      <= IDLE;
      pll_rst <= 1'b0;
      cnt     <= INIT_CNT;
    end else if (lock_loss) begin
      st      <= PULSE;
      pll_rst <= 1'b1;
      cnt     <= PULSE_LOAD;
    end else if (cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
    end else if (st == PULSE) begin
      st      <= IDLE;
      pll_rst <= 1'b0;
    end
  end

  assign rst_src = rst_req | ~lk_s | pll_rst;

  // rst drops on the same edge that takes rcnt from 1 to 0.
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      rst  <= 1'b1;
      rcnt <= RST_LOAD;
    end else if (rst_src) begin
      rst  <= 1'b1;
      rcnt <= RST_LOAD;
    end else if (rcnt != 8'd0) begin
      rcnt <= rcnt - 8'd1;
      if (rcnt == 8'd1) rst <= 1'b0;
    end
  end

  assign game_src = rst | downloading;

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      game_rst <= 1'b1;
      gcnt     <= RST_LOAD;
    end else if (game_src) begin
      game_rst <= 1'b1;
      gcnt     <= RST_LOAD;
    end else if (gcnt != 8'd0) begin
      gcnt <= gcnt - 8'd1;
      if (gcnt == 8'd1) game_rst <= 1'b0;
    end
  end

  assign rst_n      = ~rst;
  assign game_rst_n = ~game_rst;

endmodule

// File: tb/tb_jtframe_pll_supervisor.sv
// Self-checking bench for jtframe_pll_supervisor.
// A timestamp model (edge index of the last reset source, last lock loss,
// last game reset source) predicts every output on every cycle; directed
// scenarios add literal duration checks.
module tb_jtframe_pll_supervisor;

  localparam int PLL_RST_LEN = 256;
  localparam int RST_LEN     = 16;
  localparam int HMAX        = 8192;

  logic clk_sys;
  logic RESET, pll_locked, rst_req, downloading;
  logic pll_rst, rst, rst_n, game_rst, game_rst_n;
  logic [7:0] cnt_probe;

  int total  = 0;
  int passed = 0;

  jtframe_pll_supervisor #(
    .PLL_RST_LEN(PLL_RST_LEN),
    .INIT_CNT   (8'hD0),
    .RST_LEN    (RST_LEN)
  ) dut (
    .clk_sys    (clk_sys),
    .RESET      (RESET),
    .pll_locked (pll_locked),
    .rst_req    (rst_req),
    .downloading(downloading),
    .pll_rst    (pll_rst),
    .rst        (rst),
    .rst_n      (rst_n),
    .game_rst   (game_rst),
    .game_rst_n (game_rst_n)
  );

  assign cnt_probe = dut.cnt;

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s at %0t: actual %0d required %0d", name, $time, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  int e          = 0;
  int reset_edge = 0;
  int last_ll    = -100000;
  int last_src   = 0;
  int last_gsrc  = 0;
  bit pll_e = 1'b0, rst_e = 1'b1, game_e = 1'b1;
  bit hist [HMAX];

  // pll_locked as sampled at edge i; anything at or before a reset edge is 0
  function automatic bit val(input int i);
    if (i < 0 || i <= reset_edge) return 1'b0;
    return hist[i % HMAX];
  endfunction

  always @(posedge clk_sys) begin
    bit src, loss, gsrc;
    e++;
    if (RESET) begin
      reset_edge = e;
      last_ll    = -100000;
      last_src   = e;
      last_gsrc  = e;
      pll_e      = 1'b0;
      rst_e      = 1'b1;
      game_e     = 1'b1;
    end else begin
      hist[e % HMAX] = pll_locked;
      // synchronised lock before this edge is the input from two edges ago
      src  = rst_req | !val(e - 2) | pll_e;
      loss = val(e - 3) & !val(e - 2);
      gsrc = rst_e | downloading;
      if (src)  last_src  = e;
      if (loss) last_ll   = e;
      if (gsrc) last_gsrc = e;
      pll_e  = (e - last_ll)   < PLL_RST_LEN;
      rst_e  = (e - last_src)  < RST_LEN;
      game_e = (e - last_gsrc) < RST_LEN;
    end
  end

  always @(negedge clk_sys) begin
    chk("cyc_pll_rst",    int'(pll_rst),    int'(pll_e));
    chk("cyc_rst",        int'(rst),        int'(rst_e));
    chk("cyc_rst_n",      int'(rst_n),      int'(!rst_e));
    chk("cyc_game_rst",   int'(game_rst),   int'(game_e));
    chk("cyc_game_rst_n", int'(game_rst_n), int'(!game_e));
  end

  // ---------------- directed scenarios ----------------
  function automatic logic sig(input int sel);
    case (sel)
      0:       return pll_rst;
      1:       return rst;
      default: return game_rst;
    endcase
  endfunction

  task automatic count_until(input int sel, input logic v, input int maxc, output int n);
    n = 0;
    do begin
      @(negedge clk_sys);
      n++;
    end while (sig(sel) !== v && n < maxc);
    if (sig(sel) !== v) chk("wait_timeout", int'(sig(sel)), int'(v));
  endtask

  task automatic startup();
    int n;
    count_until(1, 1'b0, 40, n);
    chk("rst_release_cycles", n, 18);
    count_until(2, 1'b0, 40, n);
    chk("game_release_cycles", n, 16);
    repeat (173) @(negedge clk_sys);
    chk("cnt_at_207", int'(cnt_probe), 1);
    @(negedge clk_sys);
    chk("cnt_at_208", int'(cnt_probe), 0);
    repeat (5) @(negedge clk_sys);
    chk("cnt_holds_0", int'(cnt_probe), 0);
    chk("pll_rst_after_init", int'(pll_rst), 0);
  endtask

  task automatic settle_after_lock();
    int n;
    count_until(1, 1'b0, 40, n);
    chk("relock_rst_cycles", n, 18);
    count_until(2, 1'b0, 40, n);
    chk("relock_game_cycles", n, 16);
  endtask

  initial begin
    int n, n2;
    RESET = 1'b1; pll_locked = 1'b1; rst_req = 1'b0; downloading = 1'b0;
    repeat (4) @(negedge clk_sys);
    chk("reset_pll_rst",    int'(pll_rst),    0);
    chk("reset_rst",        int'(rst),        1);
    chk("reset_rst_n",      int'(rst_n),      0);
    chk("reset_game_rst",   int'(game_rst),   1);
    chk("reset_game_rst_n", int'(game_rst_n), 0);
    #1 RESET = 1'b0;
    startup();

    // single lock drop
    #1 pll_locked = 1'b0;
    count_until(0, 1'b1, 10, n);
    chk("drop_pll_rise_delay", n, 3);
    count_until(0, 1'b0, 300, n);
    chk("drop_pll_high_cycles", n, 256);
    chk("drop_rst_held", int'(rst), 1);
    repeat (10) @(negedge clk_sys);
    chk("drop_rst_while_unlocked", int'(rst), 1);
    #1 pll_locked = 1'b1;
    settle_after_lock();

    // second loss 100 cycles into the pulse
    #1 pll_locked = 1'b0;
    count_until(0, 1'b1, 10, n);
    chk("double_pll_rise_delay", n, 3);
    repeat (96) @(negedge clk_sys);
    #1 pll_locked = 1'b1;
    @(negedge clk_sys);
    #1 pll_locked = 1'b0;
    count_until(0, 1'b0, 400, n);
    chk("double_pll_high_total", 98 + n - 1, 100 + 256);
    repeat (5) @(negedge clk_sys);
    #1 pll_locked = 1'b1;
    settle_after_lock();

    // one-cycle rst_req
    #1 rst_req = 1'b1;
    count_until(1, 1'b1, 5, n);
    #1 rst_req = 1'b0;
    count_until(1, 1'b0, 40, n2);
    chk("rst_req_total_cycles", n + n2, 1 + 16);
    chk("rst_req_pll_untouched", int'(pll_rst), 0);
    count_until(2, 1'b0, 40, n);
    chk("rst_req_game_cycles", n, 16);

    // long download
    #1 downloading = 1'b1;
    count_until(2, 1'b1, 5, n);
    chk("dl_game_rise", n, 1);
    repeat (999) @(negedge clk_sys);
    chk("dl_rst_low", int'(rst), 0);
    #1 downloading = 1'b0;
    count_until(2, 1'b0, 40, n);
    chk("dl_game_tail_cycles", n, 16);
    chk("dl_rst_still_low", int'(rst), 0);

    // RESET in the middle of a pll_rst pulse
    #1 pll_locked = 1'b0;
    count_until(0, 1'b1, 10, n);
    chk("midreset_pll_rise_delay", n, 3);
    repeat (49) @(negedge clk_sys);
    #1 RESET = 1'b1;
    #1;
    chk("midreset_pll_rst_now",  int'(pll_rst),  0);
    chk("midreset_rst_now",      int'(rst),      1);
    chk("midreset_game_rst_now", int'(game_rst), 1);
    chk("midreset_cnt_reload",   int'(cnt_probe), 8'hD0);
    pll_locked = 1'b1;
    repeat (3) @(negedge clk_sys);
    #1 RESET = 1'b0;
    startup();

    repeat (4) @(negedge clk_sys);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/jtframe_pll_supervisor.md
# jtframe_pll_supervisor

PLL lock supervisor and reset sequencer for the MiSTer frame top level. It watches the PLL `locked` flag in the `clk_sys` domain. When lock is lost it pulses the PLL reset for a fixed number of cycles. It also produces synchronised system and game resets that stay asserted while the clock tree or the ROM download is not ready.

## Interface

Parameters:
- `PLL_RST_LEN`, default 256: cycles `pll_rst` stays high after a lock-loss event. Range 2..256. The counter is 8 bits.
- `INIT_CNT`, default 8'hD0: counter value loaded by `RESET`.
- `RST_LEN`, default 16: cycles `rst` and `game_rst` stay high after every reset source clears. Range 1..255.

Ports:
- `clk_sys` in 1: system clock.
- `RESET` in 1: asynchronous, active-high master reset.
- `pll_locked` in 1: PLL lock flag. Asynchronous to `clk_sys` and synchronised internally.
- `rst_req` in 1: user or OSD reset request, level sensitive.
- `downloading` in 1: ROM download in progress.
- `pll_rst` out 1: reset to the PLL, active high.
- `rst` out 1: system reset, active high.
- `rst_n` out 1: always `~rst`.
- `game_rst` out 1: game core reset, active high.
- `game_rst_n` out 1: always `~game_rst`.

## Operation

Lock synchroniser:
- `pll_locked` passes through 2 flops to give `lk_s`.
- A third flop `last_locked` holds the previous `lk_s`.
- All three flops reset to 0.

PLL reset controller, states IDLE and PULSE:
- On `RESET`: `pll_rst`=0, counter `cnt`=`INIT_CNT`, state IDLE.
  - `INIT_CNT` only runs the counter down. It never raises `pll_rst`.
- Lock loss is `last_locked`=1 and `lk_s`=0. On lock loss in any state: `pll_rst`<=1, `cnt`<=`PLL_RST_LEN`-1, state PULSE.
  - A lock loss during PULSE reloads the counter, which extends the pulse.
- Otherwise, when `cnt`≠0: `cnt` decrements by 1.
- Otherwise (`cnt`=0): `pll_rst`<=0, state IDLE.
- A rising edge of lock has no effect on the controller.

System reset sequencer:
- Reset sources: `RESET`, `rst_req`, `~lk_s`, `pll_rst`. Any source active holds `rst`=1 and loads `rcnt`=`RST_LEN`.
  - `RESET` asserts `rst` asynchronously.
  - The other sources take effect on the next clock edge.
- With all sources inactive: `rcnt` decrements. `rst` deasserts on the edge where `rcnt` reaches 0.
- `rst` is registered. Deassertion is synchronous to `clk_sys`.

Game reset:
- `game_rst` = registered `rst | downloading`, with a separate counter of the same `RST_LEN`.
- `game_rst` stays high for `RST_LEN` cycles after both `rst` and `downloading` are low.
- `game_rst` is asserted asynchronously by `RESET`.

Reset values:
- `pll_rst`=0.
- `rst`=1, `rst_n`=0.
- `game_rst`=1, `game_rst_n`=0.
- `cnt`=`INIT_CNT`.
- `rcnt`=`RST_LEN`, and the game counter also loads `RST_LEN`.

## Timing

Lock loss to `pll_rst`:
- The falling edge of `pll_locked` is seen by the edge detector 2 cycles later.
- `pll_rst` rises 1 cycle after detection, 3 edges after the input falls.
- `pll_rst` stays high for exactly `PLL_RST_LEN` `clk_sys` cycles (256 by default).

Counter behaviour:
- `cnt` never wraps below 0.
- `cnt` holds at 0 in IDLE.

Reset release:
- `rst` deasserts `RST_LEN` cycles after the last source clears.
- `game_rst` deasserts `RST_LEN` cycles after that, or after `downloading` falls, whichever is later.

Simultaneous events:
- Lock loss together with `RESET`: `RESET` wins.
- Lock loss together with `cnt` reaching 0: the reload wins and `pll_rst` stays 1.

`RESET` mid-pulse:
- `pll_rst` drops immediately (asynchronous).
- The counter reloads to `INIT_CNT`.

## Test plan

- Apply and release `RESET` with `pll_locked`=1 and the other inputs 0:
  - `pll_rst` stays 0 throughout.
  - `cnt` reaches 0 after 0xD0 cycles.
  - `rst` falls 16 cycles after the synchronised lock input is high.
  - `game_rst` falls 16 cycles after `rst`.
- Lock drop: `pll_locked` 1→0 held low:
  - `pll_rst` rises 3 cycles later and is high for exactly 256 cycles.
  - `rst` is 1 throughout and remains 1 while lock stays low.
- Double lock loss: a second lock loss 100 cycles into the pulse gives a total high time of 100+256 cycles.
- `rst_req` pulse of 1 cycle while locked:
  - `rst` is high for 1+16 cycles.
  - `pll_rst` is untouched.
- `downloading`=1 for 1000 cycles with `rst` low:
  - `game_rst`=1 for the whole interval plus 16 cycles.
  - `rst` stays 0.
- `RESET` asserted at cycle 50 of a `pll_rst` pulse:
  - `pll_rst` is 0 immediately, and `rst` and `game_rst` are 1.
  - After release, the sequence restarts as in the first scenario.
